// File: rtl/redmule_tile_pkg.sv
// Shared types for the tile data path: core data port request/response,
// address decode rules and the target-index width helper.
package redmule_tile_pkg;

  localparam int unsigned TILE_ADDR_W = 32;
  localparam int unsigned TILE_DATA_W = 32;

  typedef struct packed {
    logic                     req;
    logic [TILE_ADDR_W-1:0]   addr;
    logic                     we;
    logic [TILE_DATA_W/8-1:0] be;
    logic [TILE_DATA_W-1:0]   wdata;
  } core_data_req_t;

  typedef struct packed {
    logic                   gnt;
    logic                   rvalid;
    logic [TILE_DATA_W-1:0] rdata;
    logic                   err;
    logic                   exokay;
  } core_data_rsp_t;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] base;
    logic [TILE_ADDR_W-1:0] mask;
  } addr_rule_t;

  // One extra index beyond the real targets encodes the internal error target.
  function automatic int unsigned tgt_idx_w(input int unsigned n_tgt);
    return $clog2(n_tgt + 1);
  endfunction

endpackage

// File: rtl/tile_data_addr_dec.sv
// Combinational base/mask address decoder; lowest matching index wins,
// no match selects the error target index N_TGT.
module tile_data_addr_dec
  import redmule_tile_pkg::*;
#(
  parameter int unsigned N_TGT  = 2,
  parameter int unsigned ADDR_W = TILE_ADDR_W,
  parameter int unsigned IDX_W  = tgt_idx_w(N_TGT)
) (
  input  logic [ADDR_W-1:0] addr,
  input  addr_rule_t        rules [N_TGT],
  output logic [IDX_W-1:0]  sel
);

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    sel = IDX_W'(N_TGT);
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((addr & rules[i].mask) == (rules[i].base & rules[i].mask)) begin
        sel = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tile_data_demux.sv
// Core data port demultiplexer: routes requests to N_TGT targets, keeps
// responses in order by only issuing to one target at a time.
module tile_data_demux
  import redmule_tile_pkg::*;
#(
  parameter int unsigned N_TGT        = 2,
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned ADDR_W       = TILE_ADDR_W,
  parameter int unsigned DATA_W       = TILE_DATA_W,
  parameter bit          PROTO_ASSERT = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  core_data_req_t core_req_i,
  output core_data_rsp_t core_rsp_o,
  output core_data_req_t tgt_req_o  [N_TGT],
  input  core_data_rsp_t tgt_rsp_i  [N_TGT],
  input  addr_rule_t     tgt_rule_i [N_TGT]
);

  localparam int unsigned       IDX_W     = tgt_idx_w(N_TGT);
  localparam int unsigned       CNT_W     = $clog2(MAX_OUTST + 1);
  localparam logic [IDX_W-1:0]  ERR_IDX   = IDX_W'(N_TGT);
  localparam logic [DATA_W-1:0] ERR_RDATA = '0;

  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  last_tgt;
  logic [CNT_W-1:0]  cnt;
  logic              err_pend_p1;
  logic              issue_ok;
  logic              sel_gnt;
  logic              req_fire;
  logic              rsp_fire;
  logic              cnt_live;
  logic              proto_viol;
  core_data_rsp_t    last_rsp;

  tile_data_addr_dec #(
    .N_TGT  (N_TGT),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_dec (
    .addr  (core_req_i.addr),
    .rules (tgt_rule_i),
    .sel   (sel)
  );

  // Only one target may have traffic in flight, so in-order return is free.
  always_comb begin
    cnt_live = (cnt != '0);
    issue_ok = rst_ni & (cnt < CNT_W'(MAX_OUTST)) & (!cnt_live | (sel == last_tgt));
    sel_gnt  = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      tgt_req_o[i]     = core_req_i;
      tgt_req_o[i].req = core_req_i.req & (sel == IDX_W'(i)) & issue_ok;
      if (sel == IDX_W'(i)) sel_gnt = tgt_rsp_i[i].gnt;
    end
  end

  // Response source follows the target of the oldest outstanding transaction.
  always_comb begin
    last_rsp        = '0;
    last_rsp.rvalid = err_pend_p1;
    last_rsp.rdata  = ERR_RDATA;
    last_rsp.err    = 1'b1;
    last_rsp.exokay = 1'b0;
    proto_viol      = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (last_tgt == IDX_W'(i)) last_rsp = tgt_rsp_i[i];
      if (tgt_rsp_i[i].rvalid && (!cnt_live || last_tgt != IDX_W'(i))) proto_viol = 1'b1;
    end
  end

  always_comb begin
    core_rsp_o        = '0;
    core_rsp_o.gnt    = (sel == ERR_IDX) ? issue_ok : (issue_ok & sel_gnt);
    core_rsp_o.rvalid = cnt_live & last_rsp.rvalid;
    core_rsp_o.rdata  = cnt_live ? last_rsp.rdata : '0;
    core_rsp_o.err    = cnt_live & last_rsp.err;
    core_rsp_o.exokay = cnt_live & last_rsp.exokay;
    req_fire          = core_req_i.req & core_rsp_o.gnt;
    rsp_fire          = core_rsp_o.rvalid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt         <= '0;
      last_tgt    <= '0;
      err_pend_p1 <= 1'b0;
    end else begin
      if (req_fire) last_tgt <= sel;
      err_pend_p1 <= req_fire & (sel == ERR_IDX);
      case ({req_fire, rsp_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Stray responses never reach the core; this flags them in simulation.
  always_ff @(posedge clk_i) begin
    if (PROTO_ASSERT && rst_ni) assert (!proto_viol);
  end

endmodule

// File: tb/tb_tile_data_demux.sv
// Directed bench for tile_data_demux: decode, error target, full, switch,
// simultaneous grant/response and mid-operation reset.
module tb_tile_data_demux;
  import redmule_tile_pkg::*;

  logic           clk;
  logic           rst_n;
  core_data_req_t core_req;
  core_data_rsp_t core_rsp;
  core_data_req_t tgt_req  [2];
  core_data_rsp_t tgt_rsp  [2];
  addr_rule_t     tgt_rule [2];
  logic           t_gnt    [2];
  logic           t_rv     [2];
  logic [31:0]    t_rdata  [2];

  int checks = 0;
  int errors = 0;

  tile_data_demux #(
    .N_TGT        (2),
    .MAX_OUTST    (4),
    .PROTO_ASSERT (1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .core_req_i (core_req),
    .core_rsp_o (core_rsp),
    .tgt_req_o  (tgt_req),
    .tgt_rsp_i  (tgt_rsp),
    .tgt_rule_i (tgt_rule)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt_rsp[i]        = '0;
      tgt_rsp[i].gnt    = t_gnt[i];
      tgt_rsp[i].rvalid = t_rv[i];
      tgt_rsp[i].rdata  = t_rdata[i];
      tgt_rsp[i].exokay = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic [31:0] addr, input logic we);
    core_req.req   = req;
    core_req.addr  = addr;
    core_req.we    = we;
    core_req.be    = 4'hF;
    core_req.wdata = 32'hA5A5_0000 ^ addr;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = '0;
    tgt_rule[0] = '{base: 32'h1000_0000, mask: 32'hFFFF_0000};
    tgt_rule[1] = '{base: 32'h2000_0000, mask: 32'hF000_0000};
    for (int i = 0; i < 2; i++) begin
      t_gnt[i] = 1'b0; t_rv[i] = 1'b0; t_rdata[i] = '0;
    end

    // Reset: outputs quiet whatever the inputs do
    set_req(1'b1, 32'h1000_0010, 1'b0);
    t_gnt[0] = 1'b1; t_rv[0] = 1'b1;
    tick(); tick();
    chk("rst_gnt",    core_rsp.gnt, 0);
    chk("rst_rvalid", core_rsp.rvalid, 0);
    chk("rst_err",    core_rsp.err, 0);
    chk("rst_req0",   tgt_req[0].req, 0);
    chk("rst_cnt",    dut.cnt, 0);
    rst_n = 1'b1;
    set_req(1'b0, 32'h0, 1'b0);
    t_gnt[0] = 1'b0; t_rv[0] = 1'b0;
    tick();

    // Decode: write to T1, grant follows T1
    set_req(1'b1, 32'h2000_0040, 1'b1);
    #1;
    chk("dec_req1",    tgt_req[1].req, 1);
    chk("dec_req0",    tgt_req[0].req, 0);
    chk("dec_addr1",   tgt_req[1].addr, 32'h2000_0040);
    chk("dec_we1",     tgt_req[1].we, 1);
    chk("dec_gnt_lo",  core_rsp.gnt, 0);
    t_gnt[1] = 1'b1;
    #1;
    chk("dec_gnt_hi",  core_rsp.gnt, 1);
    tick();
    set_req(1'b0, 32'h0, 1'b0); t_gnt[1] = 1'b0;
    chk("dec_cnt1",    dut.cnt, 1);
    t_rv[1] = 1'b1; t_rdata[1] = 32'h0000_CAFE;
    #1;
    chk("dec_rvalid",  core_rsp.rvalid, 1);
    chk("dec_rdata",   core_rsp.rdata, 32'h0000_CAFE);
    tick();
    t_rv[1] = 1'b0;
    chk("dec_cnt0",    dut.cnt, 0);

    // Error target: zero-cycle grant, response one cycle later
    set_req(1'b1, 32'h3000_0000, 1'b0);
    #1;
    chk("err_gnt",     core_rsp.gnt, 1);
    chk("err_req0",    tgt_req[0].req, 0);
    chk("err_req1",    tgt_req[1].req, 0);
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    #1;
    chk("err_rvalid",  core_rsp.rvalid, 1);
    chk("err_err",     core_rsp.err, 1);
    chk("err_rdata",   core_rsp.rdata, 0);
    chk("err_exokay",  core_rsp.exokay, 0);
    tick();
    chk("err_done",    core_rsp.rvalid, 0);

    // Back-to-back error grants give back-to-back error responses
    set_req(1'b1, 32'h3000_0004, 1'b0);
    tick();
    #1;
    chk("err2_gnt",    core_rsp.gnt, 1);
    chk("err2_rv_a",   core_rsp.rvalid, 1);
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    #1;
    chk("err2_rv_b",   core_rsp.rvalid, 1);
    chk("err2_cnt",    dut.cnt, 1);
    tick();
    chk("err2_cnt0",   dut.cnt, 0);

    // Full: four grants to silent T0, fifth held
    set_req(1'b1, 32'h1000_0010, 1'b0);
    t_gnt[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("full_gnt%0d", k), core_rsp.gnt, 1);
      tick();
    end
    #1;
    chk("full_gnt4",   core_rsp.gnt, 0);
    chk("full_req0",   tgt_req[0].req, 0);
    chk("full_cnt",    dut.cnt, 4);
    t_rv[1] = 1'b1;
    #1;
    chk("stray1_rv",   core_rsp.rvalid, 0);
    chk("stray1_flag", dut.proto_viol, 1);
    tick();
    t_rv[1] = 1'b0;
    chk("stray1_cnt",  dut.cnt, 4);
    t_rv[0] = 1'b1; t_rdata[0] = 32'h0000_0001;
    #1;
    chk("full_rv",     core_rsp.rvalid, 1);
    chk("full_gnt_rv", core_rsp.gnt, 0);
    tick();
    t_rv[0] = 1'b0;
    chk("full_cnt3",   dut.cnt, 3);
    chk("full_gnt5",   core_rsp.gnt, 1);
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    chk("full_cnt4b",  dut.cnt, 4);
    t_rv[0] = 1'b1;
    tick(); tick();
    t_rv[0] = 1'b0;
    chk("drain_cnt2",  dut.cnt, 2);

    // Simultaneous grant and response leaves cnt unchanged
    set_req(1'b1, 32'h1000_0020, 1'b0);
    t_rv[0] = 1'b1;
    #1;
    chk("sim_gnt",     core_rsp.gnt, 1);
    chk("sim_rv",      core_rsp.rvalid, 1);
    tick();
    t_rv[0] = 1'b0;
    set_req(1'b0, 32'h0, 1'b0);
    chk("sim_cnt",     dut.cnt, 2);

    // Switch: T1 stalls until both T0 responses have returned
    set_req(1'b1, 32'h2000_0040, 1'b0);
    t_gnt[1] = 1'b1;
    #1;
    chk("sw_gnt_a",    core_rsp.gnt, 0);
    chk("sw_req1_a",   tgt_req[1].req, 0);
    tick();
    t_rv[0] = 1'b1; t_rdata[0] = 32'h0000_0011;
    #1;
    chk("sw_rdata_a",  core_rsp.rdata, 32'h11);
    chk("sw_gnt_b",    core_rsp.gnt, 0);
    tick();
    t_rdata[0] = 32'h0000_0022;
    #1;
    chk("sw_rdata_b",  core_rsp.rdata, 32'h22);
    chk("sw_gnt_c",    core_rsp.gnt, 0);
    tick();
    t_rv[0] = 1'b0;
    chk("sw_gnt_d",    core_rsp.gnt, 1);
    chk("sw_req1_d",   tgt_req[1].req, 1);
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    t_gnt[1] = 1'b0;
    t_rv[1] = 1'b1; t_rdata[1] = 32'h0000_0033;
    #1;
    chk("sw_rdata_c",  core_rsp.rdata, 32'h33);
    tick();
    t_rv[1] = 1'b0;
    chk("sw_cnt0",     dut.cnt, 0);

    // Reset mid-operation discards three outstanding T0 transactions
    set_req(1'b1, 32'h1000_0030, 1'b0);
    tick(); tick(); tick();
    chk("rst2_cnt3",   dut.cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt",    dut.cnt, 0);
    chk("rst2_gnt",    core_rsp.gnt, 0);
    chk("rst2_req0",   tgt_req[0].req, 0);
    tick();
    rst_n = 1'b1;
    set_req(1'b0, 32'h0, 1'b0);
    t_rv[0] = 1'b1;
    #1;
    chk("rst2_stray",  core_rsp.rvalid, 0);
    chk("rst2_flag",   dut.proto_viol, 1);
    tick();
    t_rv[0] = 1'b0;
    chk("rst2_cnt0",   dut.cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
